// File: rtl/riscv_dec_pkg.sv
// riscv_dec_pkg: RV32I decode constants, immediate formats and the ID/EX control bundle
package riscv_dec_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [1:0] {IMM_ZERO, IMM_I, IMM_SH, IMM_S} imm_fmt_e;
  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] func3;
    logic       func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/id_ex_decoder_imm_gen.sv
// imm_gen: builds the I, I-shift or S immediate (zero for formats without one)
module imm_gen import riscv_dec_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_fmt,
  input  logic [11:0]     i_hi,
  input  logic [4:0]      i_lo,
  output logic [XLEN-1:0] o_imm
);
  always_comb o_imm = i_fmt == IMM_I  ? {{(XLEN-12){i_hi[11]}}, i_hi} :
                      i_fmt == IMM_S  ? {{(XLEN-12){i_hi[11]}}, i_hi[11:5], i_lo} :
                      i_fmt == IMM_SH ? {{(XLEN-5){1'b0}}, i_hi[4:0]} : '0;
endmodule

// File: rtl/id_ex_decoder.sv
// id_ex_decoder: RV32I decode into a registered ID/EX control bundle with valid/ready on both sides.
// ID_ILLEGAL_CNT_EN adds a saturating count of accepted illegal instructions on illegal_cnt.
module id_ex_decoder import riscv_dec_pkg::*; #(
  parameter int XLEN = 32
`ifdef ID_ILLEGAL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      alu_op,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            illegal
`ifdef ID_ILLEGAL_CNT_EN
  , output logic [CNT_W-1:0] illegal_cnt
`endif
);
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic w_is_r, w_is_i, w_is_ld, w_is_st, w_shift, w_legal, w_acc;
  imm_fmt_e w_fmt;
  logic [XLEN-1:0] w_imm, r_imm;
  ctrl_t w_ctrl, r_ctrl;
  logic r_valid;
  assign w_op    = instr[6:0];
  assign w_f3    = instr[14:12];
  assign w_f7    = instr[31:25];
  assign w_is_r  = w_op == OP_R;
  assign w_is_i  = w_op == OP_IMM;
  assign w_is_ld = w_op == OP_LOAD;
  assign w_is_st = w_op == OP_STORE;
  assign w_shift = w_is_i && w_f3[1:0] == 2'b01;
  // slli takes only the base funct7; srli/srai (funct3[2]=1) also take the alternate
  assign w_legal = (w_is_r && (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                || (w_is_i && (!w_shift || w_f7 == F7_BASE || (w_f3[2] && w_f7 == F7_ALT)))
                || w_is_ld || w_is_st;
  assign w_fmt = !w_legal || w_is_r ? IMM_ZERO : w_is_st ? IMM_S : w_shift ? IMM_SH : IMM_I;
  always_comb begin
    w_ctrl.alu_op    = !w_legal ? ALUOP_MEM : w_is_r ? ALUOP_R : w_is_i ? ALUOP_I : ALUOP_MEM;
    w_ctrl.func3     = w_f3;
    w_ctrl.func7     = w_legal && (w_is_r || w_shift) && instr[30];
    w_ctrl.rs1       = instr[19:15];
    w_ctrl.rs2       = instr[24:20];
    w_ctrl.rd        = w_legal && !w_is_st ? instr[11:7] : 5'd0;
    w_ctrl.use_imm   = w_legal && !w_is_r;
    w_ctrl.reg_write = w_legal && !w_is_st && instr[11:7] != 5'd0;
    w_ctrl.mem_read  = w_legal && w_is_ld;
    w_ctrl.mem_write = w_legal && w_is_st;
    w_ctrl.illegal   = !w_legal;
  end
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_fmt(w_fmt),
    .i_hi (instr[31:20]),
    .i_lo (instr[11:7]),
    .o_imm(w_imm)
  );
  assign in_ready = (!r_valid || out_ready) && !flush;
  assign w_acc    = in_valid && in_ready;
  // payload only moves on acceptance, so a stalled bundle holds bit-for-bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_imm   <= '0;
    end else begin
      r_valid <= flush ? 1'b0 : w_acc ? 1'b1 : out_ready ? 1'b0 : r_valid;
      if (w_acc) begin
        r_ctrl <= w_ctrl;
        r_imm  <= w_imm;
      end
    end
  end
  assign out_valid = r_valid;
  assign alu_op    = r_ctrl.alu_op;
  assign func3     = r_ctrl.func3;
  assign func7     = r_ctrl.func7;
  assign rs1       = r_ctrl.rs1;
  assign rs2       = r_ctrl.rs2;
  assign rd        = r_ctrl.rd;
  assign imm       = r_imm;
  assign use_imm   = r_ctrl.use_imm;
  assign reg_write = r_ctrl.reg_write;
  assign mem_read  = r_ctrl.mem_read;
  assign mem_write = r_ctrl.mem_write;
  assign illegal   = r_ctrl.illegal;
`ifdef ID_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else if (w_acc && !w_legal && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign illegal_cnt = r_cnt;
`endif
endmodule
